// File: rtl/bcd_ascii_if.sv
// Valid/ready bundle between a BCD word producer, the serializer and a character consumer.
interface bcd_ascii_if #(
  parameter int DIGITS = 4,
  parameter int N      = 4,
  parameter int M      = 8
) ();
  logic                  in_valid;
  logic                  in_ready;
  logic [DIGITS*N-1:0]   in_bcd;
  logic                  out_valid;
  logic                  out_ready;
  logic [M-1:0]          out_char;
  logic                  out_err;
  logic                  out_last;

  modport master (
    output in_valid, in_bcd, out_ready,
    input  in_ready, out_valid, out_char, out_err, out_last
  );

  modport slave (
    input  in_valid, in_bcd, out_ready,
    output in_ready, out_valid, out_char, out_err, out_last
  );
endinterface

// File: rtl/bcd_ascii_serializer.sv
// Streams a packed word of BCD digits out as ASCII characters, MSD first, with invalid-digit flagging.
// Optional leading-zero blanking is compiled in with `define BCD_LEADING_ZERO_BLANK_EN.
module bcd_ascii_serializer #(
  parameter int          DIGITS       = 4,
  parameter int          N            = 4,
  parameter int          M            = 8,
  parameter logic [M-1:0] INVALID_CHAR = M'(8'h3F)
) (
  input  logic        clk,
  input  logic        rst_n,
  bcd_ascii_if.slave  bus,
  output logic [7:0]  err_cnt
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t              state_q, state_d;
  logic [DIGITS*N-1:0] word_q, word_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [M-1:0]        char_q, char_d;
  logic                err_q, err_d;
  logic                last_q, last_d;
  logic [7:0]          cnt_q, cnt_d;
`ifdef BCD_LEADING_ZERO_BLANK_EN
  logic                lz_q, lz_d;
`endif

  logic                in_ready;
  logic                accept;
  logic                beat;
  logic [DIGITS*N-1:0] sel_word;
  logic [IW-1:0]       sel_idx;
  logic [N-1:0]        digit;
  logic                blank;
  logic                sel_lz;

  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    idx_d    = idx_q;
    char_d   = char_q;
    err_d    = err_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
`ifdef BCD_LEADING_ZERO_BLANK_EN
    lz_d     = lz_q;
    sel_lz   = lz_q;
`else
    sel_lz   = 1'b0;
`endif

    // A new word may only enter on the final beat of the current one, so no bubble and no overrun.
    in_ready = rst_n && ((state_q == IDLE) || ((state_q == SEND) && last_q && bus.out_ready));
    accept   = bus.in_valid && in_ready;
    beat     = (state_q == SEND) && bus.out_ready;

    sel_word = word_q;
    sel_idx  = (idx_q != '0) ? idx_q - 1'b1 : '0;
    if (accept) begin
      sel_word = bus.in_bcd;
      sel_idx  = IW'(DIGITS - 1);
      sel_lz   = 1'b1;
    end

    digit = sel_word[sel_idx*N +: N];
`ifdef BCD_LEADING_ZERO_BLANK_EN
    blank = sel_lz && (digit == '0) && (sel_idx != '0);
`else
    blank = 1'b0;
`endif

    if (accept || (beat && (idx_q != '0))) begin
      state_d = SEND;
      word_d  = sel_word;
      idx_d   = sel_idx;
      last_d  = (sel_idx == '0);
`ifdef BCD_LEADING_ZERO_BLANK_EN
      lz_d    = sel_lz && (digit == '0);
`endif
      if (blank) begin
        char_d = M'(8'h20);
        err_d  = 1'b0;
      end else if (digit > N'(9)) begin
        char_d = INVALID_CHAR;
        err_d  = 1'b1;
      end else begin
        char_d = M'(8'h30) + M'(digit);
        err_d  = 1'b0;
      end
    end else if (beat) begin
      state_d = IDLE;
      char_d  = '0;
      err_d   = 1'b0;
      last_d  = 1'b0;
    end

    if (beat && err_q && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      word_q  <= '0;
      idx_q   <= '0;
      char_q  <= '0;
      err_q   <= 1'b0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
`ifdef BCD_LEADING_ZERO_BLANK_EN
      lz_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      char_q  <= char_d;
      err_q   <= err_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
`ifdef BCD_LEADING_ZERO_BLANK_EN
      lz_q    <= lz_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == SEND);
  assign bus.out_char  = char_q;
  assign bus.out_err   = err_q;
  assign bus.out_last  = last_q;
  assign err_cnt       = cnt_q;

endmodule

// File: tb/tb_bcd_ascii_serializer.sv
// Scoreboard bench for bcd_ascii_serializer: stimulus pushes expected characters, a monitor pops on each beat.
module tb_bcd_ascii_serializer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] err_cnt;

  bcd_ascii_if #(.DIGITS(4), .N(4), .M(8)) bus ();

  bcd_ascii_serializer #(.DIGITS(4), .N(4), .M(8), .INVALID_CHAR(8'h3F)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .err_cnt (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] ch;
    logic       err;
    logic       last;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_char got %h expected none", bus.out_char);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ({bus.out_char, bus.out_err, bus.out_last} !== {e.ch, e.err, e.last}) begin
          errors++;
          $display("FAIL stream_char got %h/%b/%b expected %h/%b/%b",
                   bus.out_char, bus.out_err, bus.out_last, e.ch, e.err, e.last);
        end
      end
    end
  end

  // Pushes the four expected characters, then presents the word until it is accepted.
  task automatic send_word(input logic [15:0] w, input logic [31:0] chars, input logic [3:0] errs);
    int n;
    exp_t e;
    for (int i = 3; i >= 0; i--) begin
      e.ch   = chars[i*8 +: 8];
      e.err  = errs[i];
      e.last = (i == 0);
      sb.push_back(e);
    end
    bus.in_valid = 1'b1;
    bus.in_bcd   = w;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout got in_ready=0 expected 1 word %h", w);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || bus.out_valid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout got %0d pending expected 0", sb.size());
    end
    @(posedge clk);
    #1;
  endtask

`ifdef BCD_LEADING_ZERO_BLANK_EN
  localparam logic [31:0] EXP_0905 = 32'h20393035;
  localparam logic [31:0] EXP_0007 = 32'h20202037;
  localparam logic [31:0] EXP_0000 = 32'h20202030;
  localparam logic [31:0] EXP_0A00 = 32'h203F3030;
  localparam logic [31:0] EXP_0001 = 32'h20202031;
`else
  localparam logic [31:0] EXP_0905 = 32'h30393035;
  localparam logic [31:0] EXP_0007 = 32'h30303037;
  localparam logic [31:0] EXP_0000 = 32'h30303030;
  localparam logic [31:0] EXP_0A00 = 32'h303F3030;
  localparam logic [31:0] EXP_0001 = 32'h30303031;
`endif

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_bcd    = '0;
    bus.out_ready = 1'b1;

    #23;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_char", 32'(bus.out_char), 32'h00);
    chk("rst_out_err", 32'(bus.out_err), 32'd0);
    chk("rst_out_last", 32'(bus.out_last), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Basic order and in_ready only on the last beat.
    send_word(16'h1234, 32'h31323334, 4'b0000);
    repeat (3) begin
      @(negedge clk);
      chk("basic_in_ready_mid", 32'(bus.in_ready), 32'd0);
    end
    @(negedge clk);
    chk("basic_in_ready_last", 32'(bus.in_ready), 32'd1);
    wait_drain();

    // Backpressure on the second character.
    send_word(16'h0905, EXP_0905, 4'b0000);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("stall_hold", {23'd0, bus.out_valid, bus.out_char}, {23'd0, 1'b1, 8'h39});
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    wait_drain();

    // Invalid digits and saturation of the error counter.
    send_word(16'h12A4, 32'h31323F34, 4'b0010);
    wait_drain();
    chk("err_cnt_one", 32'(err_cnt), 32'd1);
    send_word(16'hFFFF, 32'h3F3F3F3F, 4'b1111);
    wait_drain();
    chk("err_cnt_five", 32'(err_cnt), 32'd5);
    for (int k = 0; k < 64; k++) begin
      send_word(16'hFFFF, 32'h3F3F3F3F, 4'b1111);
    end
    wait_drain();
    chk("err_cnt_sat", 32'(err_cnt), 32'hFF);

    // Back-to-back words with no bubble.
    send_word(16'h5678, 32'h35363738, 4'b0000);
    fork
      send_word(16'h9012, 32'h39303132, 4'b0000);
      begin
        repeat (8) begin
          @(negedge clk);
          chk("b2b_out_valid", 32'(bus.out_valid), 32'd1);
        end
      end
    join
    wait_drain();

    // Leading zeros.
    send_word(16'h0007, EXP_0007, 4'b0000);
    wait_drain();
    send_word(16'h0000, EXP_0000, 4'b0000);
    wait_drain();
    send_word(16'h0A00, EXP_0A00, 4'b0100);
    wait_drain();
    chk("err_cnt_still_sat", 32'(err_cnt), 32'hFF);

    // Reset after two characters of a word.
    send_word(16'h4321, 32'h34333231, 4'b0000);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
    sb.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rel_out_char", 32'(bus.out_char), 32'h00);
    chk("rel_out_last", 32'(bus.out_last), 32'd0);
    @(posedge clk);
    #1;
    send_word(16'h0001, EXP_0001, 4'b0000);
    wait_drain();
    chk("final_err_cnt", 32'(err_cnt), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
